pid_loop_sequencer: RTL

- Wishbone Classic master that runs one PID control iteration per accepted process-value sample.
- Per sample: writes PV into the PID slave, waits for the slave's u(n) computation to finish, reads u(n) back over Wishbone, and presents it as an actuator command with a one-cycle valid pulse.
- Sits between the sensor front-end and the 32-bit Wishbone port of the PID core.
- Owns the PID's per-sample sequencing and detects a hung slave via a timeout.

---
 rtl/pid_loop_sequencer.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/pid_loop_sequencer.sv
// pid_loop_sequencer
// Wishbone Classic master that runs one PID iteration per accepted PV sample:
// write PV, wait for the PID core to finish computing u(n), read u(n) back and
// present it on o_cmd with a one-cycle o_cmd_valid pulse. A per-state cycle
// counter aborts the iteration if the slave hangs.
// Optional build macro: PID_CMD_SAT_EN -- clamp the command to the signed
// 16-bit range and report clamping on o_cmd_sat.
module pid_loop_sequencer #(
  parameter int                   wb_nb     = 32,
  parameter int                   adr_wb_nb = 16,
  parameter logic [adr_wb_nb-1:0] PV_ADR    = 'h0010,
  parameter logic [adr_wb_nb-1:0] UN_ADR    = 'h0020,
  parameter int                   TIMEOUT   = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_sample_valid,
  input  logic [15:0]          i_sample,
  output logic                 o_sample_ready,
  output logic                 o_wb_cyc,
  output logic                 o_wb_stb,
  output logic                 o_wb_we,
  output logic [adr_wb_nb-1:0] o_wb_adr,
  output logic [wb_nb-1:0]     o_wb_data,
  input  logic                 i_wb_ack,
  input  logic [wb_nb-1:0]     i_wb_data,
  input  logic                 i_pid_valid,
  output logic [31:0]          o_cmd,
  output logic                 o_cmd_valid,
  output logic                 o_cmd_sat,
  output logic                 o_busy,
  output logic                 o_timeout,
  input  logic                 i_clr_timeout
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WR_PV     = 3'd1;
  localparam logic [2:0] S_GAP       = 3'd2;
  localparam logic [2:0] S_WAIT_BUSY = 3'd3;
  localparam logic [2:0] S_WAIT_DONE = 3'd4;
  localparam logic [2:0] S_RD_UN     = 3'd5;
  localparam logic [2:0] S_OUT       = 3'd6;

  // Counter value seen on the last permitted cycle of a waiting state.
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  logic [2:0]           state_reg, state_next;
  logic [15:0]          cnt_reg, cnt_next;
  logic                 cyc_reg, cyc_next;
  logic                 we_reg, we_next;
  logic [adr_wb_nb-1:0] adr_reg, adr_next;
  logic [wb_nb-1:0]     wdata_reg, wdata_next;
  logic [wb_nb-1:0]     result_reg, result_next;
  logic [31:0]          cmd_reg, cmd_next;
  logic                 cmd_valid_reg, cmd_valid_next;
  logic                 timeout_reg, timeout_next;
  logic                 timeout_hit;
`ifdef PID_CMD_SAT_EN
  localparam logic signed [31:0] SAT_MAX = 32'sd32767;
  localparam logic signed [31:0] SAT_MIN = -32'sd32768;
  logic                 sat_reg, sat_next;
`endif

  // Next-state, bus and timeout decisions for the sequencing FSM.
  always_comb begin
    state_next     = state_reg;
    cyc_next       = cyc_reg;
    we_next        = we_reg;
    adr_next       = adr_reg;
    wdata_next     = wdata_reg;
    result_next    = result_reg;
    cmd_next       = cmd_reg;
    cmd_valid_next = 1'b0;
    timeout_hit    = 1'b0;
`ifdef PID_CMD_SAT_EN
    sat_next       = 1'b0;
`endif
    case (state_reg)
      S_IDLE: begin
        if (i_sample_valid) begin
          wdata_next = {{(wb_nb-16){i_sample[15]}}, i_sample};
          adr_next   = PV_ADR;
          cyc_next   = 1'b1;
          we_next    = 1'b1;
          state_next = S_WR_PV;
        end
      end
      S_WR_PV: begin
        // An ack on the final allowed cycle still completes the write.
        if (i_wb_ack) begin
          cyc_next   = 1'b0;
          we_next    = 1'b0;
          state_next = S_GAP;
        end else if (cnt_reg == CNT_LAST) begin
          timeout_hit = 1'b1;
        end
      end
      S_GAP: begin
        state_next = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // Missing the busy phase only means the core was quick; not an error.
        if (!i_pid_valid || cnt_reg == CNT_LAST) begin
          state_next = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (i_pid_valid) begin
          cyc_next   = 1'b1;
          we_next    = 1'b0;
          adr_next   = UN_ADR;
          state_next = S_RD_UN;
        end else if (cnt_reg == CNT_LAST) begin
          timeout_hit = 1'b1;
        end
      end
      S_RD_UN: begin
        if (i_wb_ack) begin
          result_next = i_wb_data;
          cyc_next    = 1'b0;
          state_next  = S_OUT;
        end else if (cnt_reg == CNT_LAST) begin
          timeout_hit = 1'b1;
        end
      end
      S_OUT: begin
`ifdef PID_CMD_SAT_EN
        if ($signed(result_reg) > SAT_MAX) begin
          cmd_next = SAT_MAX;
          sat_next = 1'b1;
        end else if ($signed(result_reg) < SAT_MIN) begin
          cmd_next = SAT_MIN;
          sat_next = 1'b1;
        end else begin
          cmd_next = 32'(result_reg);
        end
`else
        cmd_next = 32'(result_reg);
`endif
        cmd_valid_next = 1'b1;
        state_next     = S_IDLE;
      end
      default: begin
        cyc_next   = 1'b0;
        we_next    = 1'b0;
        state_next = S_IDLE;
      end
    endcase

    // Abort: release the bus and return to IDLE without touching o_cmd.
    if (timeout_hit) begin
      cyc_next   = 1'b0;
      we_next    = 1'b0;
      state_next = S_IDLE;
    end

    // Cycle counter restarts on every state change and only runs while waiting.
    if (state_next != state_reg || state_reg == S_IDLE ||
        state_reg == S_GAP || state_reg == S_OUT) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt_reg + 16'd1;
    end

    // A fresh timeout takes precedence over a simultaneous clear.
    if (timeout_hit) begin
      timeout_next = 1'b1;
    end else if (i_clr_timeout) begin
      timeout_next = 1'b0;
    end else begin
      timeout_next = timeout_reg;
    end
  end

  // State and registered outputs; reset releases the bus immediately.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      cyc_reg       <= 1'b0;
      we_reg        <= 1'b0;
      adr_reg       <= '0;
      wdata_reg     <= '0;
      result_reg    <= '0;
      cmd_reg       <= '0;
      cmd_valid_reg <= 1'b0;
      timeout_reg   <= 1'b0;
`ifdef PID_CMD_SAT_EN
      sat_reg       <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      cyc_reg       <= cyc_next;
      we_reg        <= we_next;
      adr_reg       <= adr_next;
      wdata_reg     <= wdata_next;
      result_reg    <= result_next;
      cmd_reg       <= cmd_next;
      cmd_valid_reg <= cmd_valid_next;
      timeout_reg   <= timeout_next;
`ifdef PID_CMD_SAT_EN
      sat_reg       <= sat_next;
`endif
    end
  end

  assign o_sample_ready = (state_reg == S_IDLE);
  assign o_busy         = (state_reg != S_IDLE);
  assign o_wb_cyc       = cyc_reg;
  assign o_wb_stb       = cyc_reg;
  assign o_wb_we        = we_reg;
  assign o_wb_adr       = adr_reg;
  assign o_wb_data      = wdata_reg;
  assign o_cmd          = cmd_reg;
  assign o_cmd_valid    = cmd_valid_reg;
  assign o_timeout      = timeout_reg;
`ifdef PID_CMD_SAT_EN
  assign o_cmd_sat      = sat_reg;
`else
  assign o_cmd_sat      = 1'b0;
`endif

endmodule
